// File: rtl/block2x2_mul_responder.sv
`default_nettype none
// ============================================================================
// Module  : block2x2_mul_responder
// Brief   : Captures two 2x2 signed fixed-point blocks, computes C = A x B with
//           one shared multiplier over 8 cycles, holds C until acknowledged.
//           Define BLK_MUL_SATURATE_EN for saturating results (default: wrap).
// Revision: 1.0
// ============================================================================
module block2x2_mul_responder #(
   parameter int DATA_WIDTH = 32,
   parameter int FRAC_BITS  = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_stable,
   input  logic                  c_ack,
   input  logic [DATA_WIDTH-1:0] a11,
   input  logic [DATA_WIDTH-1:0] a12,
   input  logic [DATA_WIDTH-1:0] a21,
   input  logic [DATA_WIDTH-1:0] a22,
   input  logic [DATA_WIDTH-1:0] b11,
   input  logic [DATA_WIDTH-1:0] b12,
   input  logic [DATA_WIDTH-1:0] b21,
   input  logic [DATA_WIDTH-1:0] b22,
   output logic                  ab_ack,
   output logic                  out_stable,
   output logic                  ready,
   output logic [DATA_WIDTH-1:0] c11,
   output logic [DATA_WIDTH-1:0] c12,
   output logic [DATA_WIDTH-1:0] c21,
   output logic [DATA_WIDTH-1:0] c22
);

   localparam int c_PW = 2 * DATA_WIDTH;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COMPUTE = 2'd1,
      S_DONE    = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_next;

   logic                         r_in_stable_d;
   logic                         w_capture;
   logic [2:0]                   r_cnt;
   logic signed [DATA_WIDTH-1:0] r_a [0:3];
   logic signed [DATA_WIDTH-1:0] r_b [0:3];
   logic signed [DATA_WIDTH-1:0] r_c [0:3];
   logic signed [c_PW-1:0]       r_acc;
   logic signed [DATA_WIDTH-1:0] w_op_a;
   logic signed [DATA_WIDTH-1:0] w_op_b;
   logic signed [c_PW-1:0]       w_prod_full;
   logic signed [c_PW-1:0]       w_prod;
   logic signed [c_PW:0]         w_sum;
   logic signed [DATA_WIDTH-1:0] w_fit;

   assign w_capture = (r_state == S_IDLE) && in_stable && !r_in_stable_d;
   assign ready     = (r_state == S_IDLE);

   // cnt = {row, col, k}: A[row][k] * B[k][col], operand regs indexed {r,c}
   assign w_op_a = r_a[{r_cnt[2], r_cnt[0]}];
   assign w_op_b = r_b[{r_cnt[0], r_cnt[1]}];

   assign w_prod_full = $signed({{DATA_WIDTH{w_op_a[DATA_WIDTH-1]}}, w_op_a})
                      * $signed({{DATA_WIDTH{w_op_b[DATA_WIDTH-1]}}, w_op_b});
   assign w_prod      = w_prod_full >>> FRAC_BITS;
   assign w_sum       = $signed({r_acc[c_PW-1], r_acc}) + $signed({w_prod[c_PW-1], w_prod});

`ifdef BLK_MUL_SATURATE_EN
   logic w_in_range;
   assign w_in_range = (&w_sum[c_PW:DATA_WIDTH-1]) | ~(|w_sum[c_PW:DATA_WIDTH-1]);
   assign w_fit = w_in_range ? w_sum[DATA_WIDTH-1:0]
                : (w_sum[c_PW] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                               : {1'b0, {(DATA_WIDTH-1){1'b1}}});
`else
   logic w_unused_sum_hi;
   assign w_fit           = w_sum[DATA_WIDTH-1:0];
   assign w_unused_sum_hi = ^w_sum[c_PW:DATA_WIDTH];
`endif

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:    if (w_capture)       w_state_next = S_COMPUTE;
         S_COMPUTE: if (r_cnt == 3'd7)   w_state_next = S_DONE;
         S_DONE:    if (c_ack)           w_state_next = S_IDLE;
         default:                        w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_in_stable_d <= 1'b0;
         ab_ack        <= 1'b0;
         out_stable    <= 1'b0;
         r_cnt         <= 3'd0;
         r_acc         <= '0;
         for (int i = 0; i < 4; i++) begin
            r_a[i] <= '0;
            r_b[i] <= '0;
            r_c[i] <= '0;
         end
      end else begin
         r_in_stable_d <= in_stable;
         ab_ack        <= w_capture;
         if (w_capture) begin
            r_a[0] <= a11;
            r_a[1] <= a12;
            r_a[2] <= a21;
            r_a[3] <= a22;
            r_b[0] <= b11;
            r_b[1] <= b12;
            r_b[2] <= b21;
            r_b[3] <= b22;
            r_cnt  <= 3'd0;
         end
         if (r_state == S_COMPUTE) begin
            r_cnt <= r_cnt + 3'd1;
            if (!r_cnt[0]) begin
               r_acc <= w_prod;
            end else begin
               r_c[r_cnt[2:1]] <= w_fit;
            end
            if (r_cnt == 3'd7) begin
               out_stable <= 1'b1;
            end
         end
         if ((r_state == S_DONE) && c_ack) begin
            out_stable <= 1'b0;
         end
      end
   end

   assign c11 = r_c[0];
   assign c12 = r_c[1];
   assign c21 = r_c[2];
   assign c22 = r_c[3];

endmodule
`default_nettype wire

// File: tb/tb_block2x2_mul_responder.sv
`default_nettype none
// Testbench for block2x2_mul_responder: randomized jobs checked by a scoreboard
// against a matrix-level reference model, plus directed boundary scenarios.
module tb_block2x2_mul_responder;
   localparam int DW   = 32;
   localparam int FRAC = 0;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic in_stable = 1'b0;
   logic c_ack = 1'b0;
   logic [DW-1:0] a11 = '0, a12 = '0, a21 = '0, a22 = '0;
   logic [DW-1:0] b11 = '0, b12 = '0, b21 = '0, b22 = '0;
   logic ab_ack, out_stable, ready;
   logic [DW-1:0] c11, c12, c21, c22;

   block2x2_mul_responder #(.DATA_WIDTH(DW), .FRAC_BITS(FRAC)) dut (
      .clk(clk), .reset(reset), .in_stable(in_stable), .c_ack(c_ack),
      .a11(a11), .a12(a12), .a21(a21), .a22(a22),
      .b11(b11), .b12(b12), .b21(b21), .b22(b22),
      .ab_ack(ab_ack), .out_stable(out_stable), .ready(ready),
      .c11(c11), .c12(c12), .c21(c21), .c22(c22)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;
   int ack_count = 0;
   int result_count = 0;
   logic [4*DW-1:0] exp_c_q[$];
   int exp_cyc_q[$];
   int ack_q[$];

   task automatic check(input string name, input logic [4*DW-1:0] act, input logic [4*DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: C[i][j] = fit(sum_k (A[i][k]*B[k][j]) >>> FRAC) in wide integer arithmetic
   function automatic logic [DW-1:0] fit_ref(input logic signed [127:0] v);
      logic [127:0] r;
`ifdef BLK_MUL_SATURATE_EN
      logic signed [127:0] mx, mn;
      mx = (128'sd1 <<< (DW-1)) - 128'sd1;
      mn = -(128'sd1 <<< (DW-1));
      if (v > mx) r = mx;
      else if (v < mn) r = mn;
      else r = v;
`else
      r = v;
`endif
      return r[DW-1:0];
   endfunction

   function automatic logic signed [127:0] prod_ref(input logic [DW-1:0] x, input logic [DW-1:0] y);
      logic signed [127:0] ex, ey;
      ex = $signed(x);
      ey = $signed(y);
      return (ex * ey) >>> FRAC;
   endfunction

   function automatic logic [4*DW-1:0] model(input logic [DW-1:0] a[4], input logic [DW-1:0] b[4]);
      logic [4*DW-1:0] res;
      res = '0;
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 2; j++)
            res[(3 - (i*2 + j))*DW +: DW] =
               fit_ref(prod_ref(a[i*2], b[j]) + prod_ref(a[i*2+1], b[2+j]));
      return res;
   endfunction

   function automatic logic [4*DW-1:0] pack4(input int x0, input int x1, input int x2, input int x3);
      logic [DW-1:0] v0, v1, v2, v3;
      v0 = x0; v1 = x1; v2 = x2; v3 = x3;
      return {v0, v1, v2, v3};
   endfunction

   // Monitor: checks every ab_ack pulse and every presented result against the scoreboard
   initial begin
      logic prev_os;
      int e;
      prev_os = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            if (ab_ack) begin
               ack_count++;
               if (ack_q.size() == 0) check("ab_ack_unexpected", 1, 0);
               else begin
                  e = ack_q.pop_front();
                  check("ab_ack_timing", cyc, e);
               end
            end
            if (out_stable && !prev_os) begin
               result_count++;
               if (exp_c_q.size() == 0) check("result_unexpected", 1, 0);
               else begin
                  check("result_c", {c11, c12, c21, c22}, exp_c_q.pop_front());
                  e = exp_cyc_q.pop_front();
                  check("result_latency", cyc - e, 8);
               end
            end
            prev_os = out_stable;
         end else begin
            prev_os = 1'b0;
         end
      end
   end

   logic [DW-1:0] ta[4];
   logic [DW-1:0] tbv[4];

   task automatic start_job(input bit hold);
      int n;
      n = 0;
      while (!ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("ready_before_job", ready, 1);
      {a11, a12, a21, a22} = {ta[0], ta[1], ta[2], ta[3]};
      {b11, b12, b21, b22} = {tbv[0], tbv[1], tbv[2], tbv[3]};
      in_stable = 1'b1;
      @(posedge clk);
      #1;
      exp_c_q.push_back(model(ta, tbv));
      exp_cyc_q.push_back(cyc);
      ack_q.push_back(cyc);
      @(negedge clk);
      if (!hold) in_stable = 1'b0;
   endtask

   task automatic wait_out_stable();
      int n;
      n = 0;
      while (!out_stable && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("out_stable_timeout", out_stable, 1);
   endtask

   task automatic do_ack(input int delay);
      repeat (delay) @(negedge clk);
      c_ack = 1'b1;
      @(negedge clk);
      c_ack = 1'b0;
      check("ack_out_stable_low", out_stable, 0);
      check("ack_ready_high", ready, 1);
   endtask

   task automatic set_job1();
      ta  = '{32'd1, 32'd2, 32'd3, 32'd4};
      tbv = '{32'd5, 32'd6, 32'd7, 32'd8};
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [4*DW-1:0] snap;
      bit bad_c, bad_os, bad_rdy;
      int a0, r0;

      repeat (3) @(negedge clk);
      check("reset_ready", ready, 1);
      check("reset_out_stable", out_stable, 0);
      check("reset_ab_ack", ab_ack, 0);
      check("reset_c", {c11, c12, c21, c22}, 0);
      reset = 1'b1;
      @(negedge clk);

      // Basic job
      set_job1();
      start_job(0);
      wait_out_stable();
      check("job1_c", {c11, c12, c21, c22}, pack4(19, 22, 43, 50));
      do_ack(1);

      // Signed operands
      ta  = '{32'hFFFFFFFF, 32'd0, 32'd0, 32'hFFFFFFFF};
      tbv = '{32'd3, 32'hFFFFFFFC, 32'd5, 32'd6};
      start_job(0);
      wait_out_stable();
      check("job2_c", {c11, c12, c21, c22}, pack4(-3, 4, -5, -6));
      do_ack(0);

      // Overflow of c11
      ta  = '{32'h40000000, 32'd0, 32'd0, 32'd0};
      tbv = '{32'h40000000, 32'd0, 32'd0, 32'd0};
      start_job(0);
      wait_out_stable();
`ifdef BLK_MUL_SATURATE_EN
      check("job3_c", {c11, c12, c21, c22}, pack4(32'h7FFFFFFF, 0, 0, 0));
`else
      check("job3_c", {c11, c12, c21, c22}, pack4(0, 0, 0, 0));
`endif
      do_ack(2);

      // Long hold in DONE with a stray in_stable pulse
      set_job1();
      start_job(0);
      wait_out_stable();
      snap = {c11, c12, c21, c22};
      bad_c = 0; bad_os = 0; bad_rdy = 0;
      for (int i = 0; i < 20; i++) begin
         in_stable = (i == 5 || i == 6);
         @(negedge clk);
         if ({c11, c12, c21, c22} !== snap) bad_c = 1;
         if (out_stable !== 1'b1) bad_os = 1;
         if (ready !== 1'b0) bad_rdy = 1;
      end
      check("done_hold_c", bad_c, 0);
      check("done_hold_out_stable", bad_os, 0);
      check("done_hold_ready", bad_rdy, 0);
      do_ack(0);

      // Reset mid-computation
      ta  = '{32'd9, 32'd8, 32'd7, 32'd6};
      tbv = '{32'd2, 32'd3, 32'd4, 32'd5};
      start_job(0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      check("midreset_c", {c11, c12, c21, c22}, 0);
      check("midreset_out_stable", out_stable, 0);
      check("midreset_ab_ack", ab_ack, 0);
      check("midreset_ready", ready, 1);
      void'(exp_c_q.pop_back());
      void'(exp_cyc_q.pop_back());
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      set_job1();
      start_job(0);
      wait_out_stable();
      check("rerun_c", {c11, c12, c21, c22}, pack4(19, 22, 43, 50));
      do_ack(1);

      // in_stable held high across the whole job: one capture only
      a0 = ack_count; r0 = result_count;
      ta  = '{32'd2, 32'd0, 32'd0, 32'd2};
      tbv = '{32'd1, 32'd1, 32'd1, 32'd1};
      start_job(1);
      wait_out_stable();
      do_ack(2);
      repeat (15) @(negedge clk);
      in_stable = 1'b0;
      @(negedge clk);
      check("held_ab_ack_count", ack_count - a0, 1);
      check("held_result_count", result_count - r0, 1);

      // c_ack already high when DONE is entered
      ta  = '{32'd3, 32'd1, 32'd4, 32'd1};
      tbv = '{32'd5, 32'd9, 32'd2, 32'd6};
      start_job(0);
      c_ack = 1'b1;
      wait_out_stable();
      @(negedge clk);
      check("early_ack_release", out_stable, 0);
      c_ack = 1'b0;
      check("early_ack_ready", ready, 1);

      // Randomized jobs, some with a dropped in_stable pulse during COMPUTE
      for (int j = 0; j < 25; j++) begin
         for (int k = 0; k < 4; k++) begin
            if (j % 2 == 0) begin
               ta[k]  = $urandom;
               tbv[k] = $urandom;
            end else begin
               ta[k]  = int'($urandom_range(200)) - 100;
               tbv[k] = int'($urandom_range(200)) - 100;
            end
         end
         start_job(0);
         if ($urandom_range(1) == 1) begin
            @(negedge clk);
            in_stable = 1'b1;
            @(negedge clk);
            in_stable = 1'b0;
         end
         wait_out_stable();
         do_ack(int'($urandom_range(4)));
      end

      repeat (4) @(negedge clk);
      check("scoreboard_drain", exp_c_q.size(), 0);
      check("ack_queue_drain", ack_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
